// File: rtl/dual_fetch_unit.sv
// ---------------------------------------------------------------------------
// dual_fetch_unit
//
// Dual-issue fetch stage. Holds the 8-bit word-addressed PC and presents two
// consecutive fetch addresses to an external combinational instruction
// memory. Both returned instructions are predecoded for conditional branches
// (BEQ/BNE). Each branch is predicted with a table of 2-bit saturating
// counters indexed by the low PC bits. The next PC is then chosen from
// redirect, stall, the slot-1 or slot-2 prediction, or the fall-through
// address. The only registered state is the PC and the counter table. Every
// output is a combinational function of that state and of the memory data,
// because the outputs feed the fetch/decode pipeline register directly.
//
// Ports:
//   clk              in   rising-edge clock
//   reset            in   asynchronous active-low reset
//   stall_outer      in   hold the PC (same stall that freezes fetch/decode)
//   redirect_en/pc   in   redirect from execute/decode; wins even during stall
//   upd1_en/pc/taken in   resolved-branch counter update, slot 1
//   upd2_en/pc/taken in   resolved-branch counter update, slot 2 (wins on
//                         a same-index collision)
//   imem_addr1/2     out  fetch addresses (pc, pc+1)
//   imem_rdata1/2    in   instruction words at those addresses
//   inst1_Fetch      out  slot-1 instruction
//   inst2_Fetch      out  slot-2 instruction, zero when squashed by slot 1
//   pcF              out  current PC
//   pcPlus1F         out  pc+1
//   pcPlus2_F        out  pc+2
//   pcBranchF        out  slot-1 branch target (pc+1 + inst1[7:0])
//   pcBranchF_inst2  out  slot-2 branch target (pc+2 + inst2[7:0])
//   predictionF_1/2  out  predicted-taken flags per slot
// ---------------------------------------------------------------------------
module dual_fetch_unit #(
  parameter int          BHT_BITS = 4,       // log2 of table entries, 1..8
  parameter logic [7:0]  RESET_PC = 8'h00,
  parameter logic [5:0]  BEQ_OP   = 6'h04,
  parameter logic [5:0]  BNE_OP   = 6'h05
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_outer,
  input  logic        redirect_en,
  input  logic [7:0]  redirect_pc,
  input  logic        upd1_en,
  input  logic [7:0]  upd1_pc,
  input  logic        upd1_taken,
  input  logic        upd2_en,
  input  logic [7:0]  upd2_pc,
  input  logic        upd2_taken,
  output logic [7:0]  imem_addr1,
  output logic [7:0]  imem_addr2,
  input  logic [31:0] imem_rdata1,
  input  logic [31:0] imem_rdata2,
  output logic [31:0] inst1_Fetch,
  output logic [31:0] inst2_Fetch,
  output logic [7:0]  pcF,
  output logic [7:0]  pcPlus1F,
  output logic [7:0]  pcPlus2_F,
  output logic [7:0]  pcBranchF,
  output logic [7:0]  pcBranchF_inst2,
  output logic        predictionF_1,
  output logic        predictionF_2
);

  localparam int BHT_ENTRIES = 1 << BHT_BITS;

  // Next counter value. Taken moves towards 11 and not-taken moves towards
  // 00. Both ends saturate.
  function automatic logic [1:0] sat_count(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    case ({taken, ctr})
      3'b1_11: nxt = 2'b11;
      3'b0_00: nxt = 2'b00;
      default: nxt = taken ? (ctr + 2'd1) : (ctr - 2'd1);
    endcase
    return nxt;
  endfunction

  logic [7:0]                    pc;
  logic [7:0]                    pc_next;
  logic [BHT_ENTRIES-1:0][1:0]   bht;
  logic [BHT_BITS-1:0]           idx1;
  logic [BHT_BITS-1:0]           idx2;
  logic [BHT_BITS-1:0]           upd1_idx;
  logic [BHT_BITS-1:0]           upd2_idx;
  logic                          br1;
  logic                          br2;
  logic                          upd1_apply;
  logic                          unused_upd_bits;

  // PC arithmetic wraps modulo 256 by construction of the 8-bit sums.
  assign pcF        = pc;
  assign pcPlus1F   = pc + 8'd1;
  assign pcPlus2_F  = pc + 8'd2;
  assign imem_addr1 = pc;
  assign imem_addr2 = pcPlus1F;

  // Slot 2 lives at pc+1, so its counter is looked up with that address.
  assign idx1     = pc[BHT_BITS-1:0];
  assign idx2     = pcPlus1F[BHT_BITS-1:0];
  assign upd1_idx = upd1_pc[BHT_BITS-1:0];
  assign upd2_idx = upd2_pc[BHT_BITS-1:0];

  // Upper update-PC bits do not take part in indexing.
  assign unused_upd_bits = ^{upd1_pc, upd2_pc};

  // Predecode both slots and compute both targets. Targets are produced
  // whether or not the slot holds a branch.
  always_comb begin
    br1             = (imem_rdata1[31:26] == BEQ_OP) || (imem_rdata1[31:26] == BNE_OP);
    br2             = (imem_rdata2[31:26] == BEQ_OP) || (imem_rdata2[31:26] == BNE_OP);
    pcBranchF       = pcPlus1F  + imem_rdata1[7:0];
    pcBranchF_inst2 = pcPlus2_F + imem_rdata2[7:0];
  end

  // Prediction and squash. A predicted-taken slot 1 makes slot 2 dead, so
  // slot 2 can neither predict nor issue.
  always_comb begin
    predictionF_1 = br1 & bht[idx1][1];
    predictionF_2 = br2 & ~predictionF_1 & bht[idx2][1];
    inst1_Fetch   = imem_rdata1;
    if (predictionF_1) begin
      inst2_Fetch = 32'h0000_0000;
    end else begin
      inst2_Fetch = imem_rdata2;
    end
  end

  // Next-PC selection. Redirect outranks stall so that a mispredict can
  // recover while fetch is frozen.
  always_comb begin
    pc_next = pcPlus2_F;
    if (redirect_en) begin
      pc_next = redirect_pc;
    end else if (stall_outer) begin
      pc_next = pc;
    end else if (predictionF_1) begin
      pc_next = pcBranchF;
    end else if (predictionF_2) begin
      pc_next = pcBranchF_inst2;
    end else begin
      pc_next = pcPlus2_F;
    end
  end

  // PC register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_next;
    end
  end

  // When both update ports hit the same counter, only the slot-2 update is
  // applied. Slot 2 is the younger resolved branch.
  assign upd1_apply = upd1_en && !(upd2_en && (upd1_idx == upd2_idx));

  // Counter table. Updates ignore stall. Reads in the same cycle as an
  // update see the old value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bht <= {BHT_ENTRIES{2'b01}};
    end else begin
      if (upd1_apply) begin
        bht[upd1_idx] <= sat_count(bht[upd1_idx], upd1_taken);
      end
      if (upd2_en) begin
        bht[upd2_idx] <= sat_count(bht[upd2_idx], upd2_taken);
      end
    end
  end

endmodule

// File: tb/tb_dual_fetch_unit.sv
// ---------------------------------------------------------------------------
// Bench for dual_fetch_unit. A combinational memory model backs the two
// fetch ports. Directed steps push expected values into a scoreboard queue.
// Each check() call pops the queued entries and compares them against the
// selected DUT output.
// ---------------------------------------------------------------------------
module tb_dual_fetch_unit;

  localparam int S_PCF = 0, S_PC1 = 1, S_PC2 = 2, S_BR1 = 3, S_BR2 = 4;
  localparam int S_P1 = 5, S_P2 = 6, S_I1 = 7, S_I2 = 8, S_A1 = 9, S_A2 = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_outer;
  logic        redirect_en;
  logic [7:0]  redirect_pc;
  logic        upd1_en;
  logic [7:0]  upd1_pc;
  logic        upd1_taken;
  logic        upd2_en;
  logic [7:0]  upd2_pc;
  logic        upd2_taken;
  logic [7:0]  imem_addr1;
  logic [7:0]  imem_addr2;
  logic [31:0] imem_rdata1;
  logic [31:0] imem_rdata2;
  logic [31:0] inst1_Fetch;
  logic [31:0] inst2_Fetch;
  logic [7:0]  pcF;
  logic [7:0]  pcPlus1F;
  logic [7:0]  pcPlus2_F;
  logic [7:0]  pcBranchF;
  logic [7:0]  pcBranchF_inst2;
  logic        predictionF_1;
  logic        predictionF_2;

  logic [31:0] mem [256];

  assign imem_rdata1 = mem[imem_addr1];
  assign imem_rdata2 = mem[imem_addr2];

  always #5 clk = ~clk;

  dual_fetch_unit dut (
    .clk(clk), .reset(reset), .stall_outer(stall_outer),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .upd1_en(upd1_en), .upd1_pc(upd1_pc), .upd1_taken(upd1_taken),
    .upd2_en(upd2_en), .upd2_pc(upd2_pc), .upd2_taken(upd2_taken),
    .imem_addr1(imem_addr1), .imem_addr2(imem_addr2),
    .imem_rdata1(imem_rdata1), .imem_rdata2(imem_rdata2),
    .inst1_Fetch(inst1_Fetch), .inst2_Fetch(inst2_Fetch),
    .pcF(pcF), .pcPlus1F(pcPlus1F), .pcPlus2_F(pcPlus2_F),
    .pcBranchF(pcBranchF), .pcBranchF_inst2(pcBranchF_inst2),
    .predictionF_1(predictionF_1), .predictionF_2(predictionF_2)
  );

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      S_PCF:   return {24'h0, pcF};
      S_PC1:   return {24'h0, pcPlus1F};
      S_PC2:   return {24'h0, pcPlus2_F};
      S_BR1:   return {24'h0, pcBranchF};
      S_BR2:   return {24'h0, pcBranchF_inst2};
      S_P1:    return {31'h0, predictionF_1};
      S_P2:    return {31'h0, predictionF_2};
      S_I1:    return inst1_Fetch;
      S_I2:    return inst2_Fetch;
      S_A1:    return {24'h0, imem_addr1};
      S_A2:    return {24'h0, imem_addr2};
      default: return 32'hxxxx_xxxx;
    endcase
  endfunction

  task automatic expect_val(input string tag, input int sel, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = v;
    sbq.push_back(e);
  endtask

  task automatic check();
    exp_t        e;
    logic [31:0] obs;
    #1;
    while (sbq.size() > 0) begin
      e   = sbq.pop_front();
      obs = observe(e.sel);
      n_cmp++;
      assert (obs === e.exp) else begin
        n_err++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic jump(input logic [7:0] target);
    redirect_en = 1'b1;
    redirect_pc = target;
    tick();
    redirect_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 32'h0000_0000;
    mem[8'h10] = 32'h1000_0005;  // BEQ, offset 05
    mem[8'h11] = 32'hDEAD_BEEF;  // non-branch
    mem[8'h20] = 32'h0000_0033;  // non-branch
    mem[8'h21] = 32'h1400_00FE;  // BNE, offset FE
    mem[8'h53] = 32'h1000_0010;  // BEQ, offset 10
    mem[8'h65] = 32'h1400_0002;  // BNE, offset 02

    reset = 1'b0; stall_outer = 1'b0; redirect_en = 1'b0; redirect_pc = 8'h00;
    upd1_en = 1'b0; upd1_pc = 8'h00; upd1_taken = 1'b0;
    upd2_en = 1'b0; upd2_pc = 8'h00; upd2_taken = 1'b0;

    // Reset held: outputs follow the reset PC.
    #2;
    expect_val("rst_pcF", S_PCF, 32'h00);
    expect_val("rst_pc1", S_PC1, 32'h01);
    expect_val("rst_pc2", S_PC2, 32'h02);
    expect_val("rst_p1",  S_P1,  32'h0);
    expect_val("rst_p2",  S_P2,  32'h0);
    expect_val("rst_a2",  S_A2,  32'h01);
    check();
    tick();
    expect_val("rst_hold_pcF", S_PCF, 32'h00);
    check();
    reset = 1'b1;

    // Free run over NOPs through the wrap at FE.
    for (int i = 0; i < 128; i++) begin
      expect_val("run_pcF", S_PCF, 32'(2 * i));
      expect_val("run_p1",  S_P1,  32'h0);
      expect_val("run_p2",  S_P2,  32'h0);
      if (i == 127) begin
        expect_val("wrap_pc1", S_PC1, 32'hFF);
        expect_val("wrap_pc2", S_PC2, 32'h00);
      end
      check();
      tick();
    end
    expect_val("wrap_pcF", S_PCF, 32'h00);
    check();

    // Slot-1 BEQ at 10, train counter 0 to 11 while stalled.
    jump(8'h10);
    stall_outer = 1'b1;
    expect_val("s1_pcF", S_PCF, 32'h10);
    expect_val("s1_p1_cold", S_P1, 32'h0);
    expect_val("s1_br1", S_BR1, 32'h16);
    expect_val("s1_i1", S_I1, 32'h1000_0005);
    expect_val("s1_i2_live", S_I2, 32'hDEAD_BEEF);
    check();
    upd1_en = 1'b1; upd1_pc = 8'h10; upd1_taken = 1'b1;
    expect_val("s1_rdw_old", S_P1, 32'h0);
    check();
    tick();
    expect_val("s1_p1_ctr10", S_P1, 32'h1);
    check();
    tick();
    upd1_en = 1'b0;
    expect_val("s1_p1_ctr11", S_P1, 32'h1);
    expect_val("s1_i2_squash", S_I2, 32'h0);
    expect_val("s1_br1_b", S_BR1, 32'h16);
    expect_val("s1_stall_pcF", S_PCF, 32'h10);
    check();
    stall_outer = 1'b0;
    tick();
    expect_val("s1_taken_pcF", S_PCF, 32'h16);
    check();

    // Slot-2 BNE at 21 with pcF=20. Train counter 1 to 10.
    jump(8'h20);
    stall_outer = 1'b1;
    expect_val("s2_pcF", S_PCF, 32'h20);
    expect_val("s2_p1", S_P1, 32'h0);
    expect_val("s2_p2_cold", S_P2, 32'h0);
    expect_val("s2_br1", S_BR1, 32'h54);
    expect_val("s2_br2", S_BR2, 32'h20);
    expect_val("s2_a1", S_A1, 32'h20);
    expect_val("s2_a2", S_A2, 32'h21);
    check();
    upd2_en = 1'b1; upd2_pc = 8'h21; upd2_taken = 1'b1;
    expect_val("s2_rdw_old", S_P2, 32'h0);
    check();
    tick();
    upd2_en = 1'b0;
    expect_val("s2_p2_warm", S_P2, 32'h1);
    expect_val("s2_i1", S_I1, 32'h0000_0033);
    expect_val("s2_i2_live", S_I2, 32'h1400_00FE);
    check();
    stall_outer = 1'b0;
    tick();
    expect_val("s2_taken_pcF", S_PCF, 32'h20);
    expect_val("s2_p2_again", S_P2, 32'h1);
    check();

    // Stall at 30, then redirect to 44 during the stall.
    jump(8'h30);
    expect_val("st_pcF", S_PCF, 32'h30);
    check();
    stall_outer = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      expect_val("st_hold_pcF", S_PCF, 32'h30);
      check();
    end
    redirect_en = 1'b1; redirect_pc = 8'h44;
    tick();
    redirect_en = 1'b0;
    expect_val("st_redir_pcF", S_PCF, 32'h44);
    check();
    stall_outer = 1'b0;

    // Counter saturation on index 3, observed through the BEQ at 53.
    jump(8'h53);
    stall_outer = 1'b1;
    expect_val("sat_cold", S_P1, 32'h0);
    expect_val("sat_br1", S_BR1, 32'h64);
    check();
    upd1_en = 1'b1; upd1_pc = 8'h53; upd1_taken = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    expect_val("sat_top", S_P1, 32'h1);
    check();
    upd1_taken = 1'b0;
    tick();
    expect_val("sat_10", S_P1, 32'h1);
    check();
    tick();
    tick();
    expect_val("sat_00", S_P1, 32'h0);
    check();
    tick();
    upd1_taken = 1'b1;
    tick();
    expect_val("sat_bottom_01", S_P1, 32'h0);
    check();
    tick();
    upd1_en = 1'b0;
    expect_val("sat_back_10", S_P1, 32'h1);
    check();
    stall_outer = 1'b0;

    // Same-index dual update on index 5: slot 2 (not-taken) wins.
    jump(8'h65);
    stall_outer = 1'b1;
    expect_val("dual_cold", S_P1, 32'h0);
    check();
    upd1_en = 1'b1; upd1_pc = 8'h65; upd1_taken = 1'b1;
    upd2_en = 1'b1; upd2_pc = 8'h75; upd2_taken = 1'b0;
    tick();
    upd1_en = 1'b0; upd2_en = 1'b0;
    expect_val("dual_00", S_P1, 32'h0);
    check();
    upd1_en = 1'b1; upd1_pc = 8'h65; upd1_taken = 1'b1;
    tick();
    expect_val("dual_then_01", S_P1, 32'h0);
    check();
    tick();
    upd1_en = 1'b0;
    expect_val("dual_then_10", S_P1, 32'h1);
    expect_val("dual_br1", S_BR1, 32'h68);
    expect_val("dual_i2_squash", S_I2, 32'h0);
    check();
    stall_outer = 1'b0;

    // Asynchronous reset mid-run at 5A.
    jump(8'h5A);
    expect_val("mr_pcF", S_PCF, 32'h5A);
    check();
    reset = 1'b0;
    expect_val("mr_async_pcF", S_PCF, 32'h00);
    expect_val("mr_async_pc1", S_PC1, 32'h01);
    expect_val("mr_async_pc2", S_PC2, 32'h02);
    check();
    tick();
    reset = 1'b1;
    expect_val("mr_hold_pcF", S_PCF, 32'h00);
    check();
    jump(8'h53);
    stall_outer = 1'b1;
    expect_val("mr_ctr3_01", S_P1, 32'h0);
    check();
    upd1_en = 1'b1; upd1_pc = 8'h53; upd1_taken = 1'b1;
    tick();
    upd1_en = 1'b0;
    expect_val("mr_ctr3_10", S_P1, 32'h1);
    check();
    jump(8'h10);
    expect_val("mr_redir_pcF", S_PCF, 32'h10);
    expect_val("mr_ctr0_01", S_P1, 32'h0);
    expect_val("mr_i2_live", S_I2, 32'hDEAD_BEEF);
    check();
    stall_outer = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
